// File: rtl/fp8_mul_arbiter_if.sv
// Request/result bus of the FP8 multiplier arbiter: per-requester operand
// handshakes in, one result handshake out.
interface fp8_mul_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [7:0]           res_data;
    logic [ID_W-1:0]      res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/fp8_mul_arbiter.sv
// NUM_REQ requesters share one FP8 (1/3/4, bias 3) multiplier through a two-stage pipeline.
// Define FP8_MUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module fp8_mul #(
    parameter int IMPL_TYPE = 0
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);
    logic       sign;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [4:0] man_a, man_b;
    logic [9:0] prod;
    logic [3:0] frac;
    logic       guard, sticky, round_up;
    logic [4:0] frac_rnd;
    logic [4:0] e_pre, e_sum;
    logic [2:0] e_res;

    assign sign   = a[7] ^ b[7];
    assign a_zero = (a[6:4] == 3'd0);
    assign b_zero = (b[6:4] == 3'd0);
    assign a_inf  = (a[6:4] == 3'd7) && (a[3:0] == 4'd0);
    assign b_inf  = (b[6:4] == 3'd7) && (b[3:0] == 4'd0);
    assign a_nan  = (a[6:4] == 3'd7) && (a[3:0] != 4'd0);
    assign b_nan  = (b[6:4] == 3'd7) && (b[3:0] != 4'd0);
    assign man_a  = {1'b1, a[3:0]};
    assign man_b  = {1'b1, b[3:0]};

    if (IMPL_TYPE == 0) begin : g_mul_direct
        assign prod = {5'd0, man_a} * {5'd0, man_b};
    end else begin : g_mul_shift_add
        always_comb begin
            prod = '0;
            for (int i = 0; i < 5; i++) begin
                if (man_b[i]) prod = prod + ({5'd0, man_a} << i);
            end
        end
    end

    // Subnormal inputs and results below the smallest normal are flushed to zero.
    always_comb begin
        if (prod[9]) begin
            frac   = prod[8:5];
            guard  = prod[4];
            sticky = |prod[3:0];
        end else begin
            frac   = prod[7:4];
            guard  = prod[3];
            sticky = |prod[2:0];
        end
        round_up = guard & (sticky | frac[0]);
        frac_rnd = {1'b0, frac} + {4'd0, round_up};
        e_pre    = {2'b00, a[6:4]} + {2'b00, b[6:4]} + {4'd0, prod[9]};
        e_sum    = e_pre + {4'd0, frac_rnd[4]};
        e_res    = e_sum[2:0] - 3'd3;

        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) p = 8'h7F;
        else if (a_inf || b_inf)                                        p = {sign, 7'h70};
        else if (a_zero || b_zero)                                      p = {sign, 7'h00};
        else if (e_pre < 5'd4)                                          p = {sign, 7'h00};
        else if (e_sum >= 5'd10)                                        p = {sign, 7'h70};
        else                                                            p = {sign, e_res, frac_rnd[3:0]};
    end
endmodule

module fp8_mul_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst,
    fp8_mul_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int IDX_W = ID_W + 1;

    logic            s1_v_q, s1_v_d;
    logic [7:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            s2_v_q, s2_v_d;
    logic [7:0]      s2_data_q, s2_data_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;

    logic            s1_adv, s2_adv, accept, grant_found;
    logic [ID_W-1:0] grant_id;
    logic [7:0]      sel_a, sel_b, mul_p;

`ifdef FP8_MUL_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0] rr_idx;
    logic [ID_W-1:0]  rr_sel;

    // Scan farthest-first so the requester closest after the pointer wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        rr_idx      = '0;
        rr_sel      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_idx = {1'b0, ptr_q} + IDX_W'(k);
            if (rr_idx >= IDX_W'(NUM_REQ)) rr_idx = rr_idx - IDX_W'(NUM_REQ);
            rr_sel = rr_idx[ID_W-1:0];
            if (bus.req_valid[rr_sel]) begin
                grant_found = 1'b1;
                grant_id    = rr_sel;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) ptr_d = grant_id;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= ID_W'(NUM_REQ - 1);
        else     ptr_q <= ptr_d;
    end
`endif

    assign s2_adv = !s2_v_q || bus.res_ready;
    assign s1_adv = s2_adv || !s1_v_q;
    assign accept = grant_found && s1_adv && !rst;
    assign sel_a  = bus.req_a[{grant_id, 3'b000} +: 8];
    assign sel_b  = bus.req_b[{grant_id, 3'b000} +: 8];

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant_id] = 1'b1;
    end

    fp8_mul #(.IMPL_TYPE(IMPL_TYPE)) u_mul (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (mul_p)
    );

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_id_d   = s1_id_q;
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        s2_id_d   = s2_id_q;
        if (s1_adv) begin
            s1_v_d = accept;
            if (accept) begin
                s1_a_d  = sel_a;
                s1_b_d  = sel_b;
                s1_id_d = grant_id;
            end
        end
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_data_d = mul_p;
                s2_id_d   = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_id_q   <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_id_q   <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_id_q   <= s1_id_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_id_q   <= s2_id_d;
        end
    end

    assign bus.res_valid = s2_v_q;
    assign bus.res_data  = s2_data_q;
    assign bus.res_id    = s2_id_q;
endmodule

// File: doc/fp8_mul_arbiter.md
FP8_MUL_ARBITER -- requirements
Module: fp8_mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 Parameter IMPL_TYPE, default 0: passed unchanged to the internal FP8 multiplier instance.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester operand-valid.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a  input  8*NUM_REQ  operand A of requester i in bits [8i+7:8i].
REQ-008 req_b  input  8*NUM_REQ  operand B of requester i in bits [8i+7:8i].
REQ-009 res_valid  output  1  result valid.
REQ-010 res_ready  input  1  downstream accept.
REQ-011 res_data  output  8  FP8 product, format 1/3/4 with bias 3.
REQ-012 res_id  output  $clog2(NUM_REQ)  index of the requester that issued res_data.

Function
REQ-013 Requester i transfers when req_valid[i] and req_ready[i] are both high; the result transfers when res_valid and res_ready are both high.
REQ-014 Two-stage pipeline: S1 registers {a, b, id}; S2 registers {multiplier(a, b), id}; one combinational FP8 multiplier sits between S1 and S2.
REQ-015 Latency: a request accepted in cycle N presents res_valid in cycle N+2 when there is no backpressure.
REQ-016 Throughput: one request accepted per cycle when res_ready is held high.
REQ-017 Stall rule: S2 advances when it is empty or res_ready=1; S1 advances when S2 advances or S1 is empty; req_ready may assert only when S1 will be free at the clock edge.
REQ-018 Backpressure: with res_ready=0 and both stages full, all req_ready bits are 0 and no data is lost, duplicated or reordered.
REQ-019 Round-robin: a pointer holds the last granted index; the search starts at pointer+1 mod NUM_REQ and grants the first requester with req_valid=1.
REQ-020 The pointer updates only on an actual transfer; it holds when no request transfers.
REQ-021 req_ready[i] is a combinational function of req_valid, the pointer and the stall state; it never depends on req_a or req_b.
REQ-022 Once res_valid is high, res_data and res_id stay stable until the result transfers.
REQ-023 A request with req_valid=0 is never granted; with all req_valid=0, req_ready is all zero.
REQ-024 Multiplier semantics: NaN, infinity, zero, overflow and underflow results are produced by the shared FP8 multiplier unchanged; the arbiter never alters res_data.

Reset
REQ-025 While rst=1 at a clock edge: S1 and S2 are cleared to empty, res_valid=0, res_data=0, res_id=0, and the pointer is set to NUM_REQ-1 so requester 0 has first priority.
REQ-026 req_ready is all zero during any cycle in which rst=1.
REQ-027 Reset mid-operation drops all in-flight requests; no result for them ever appears.

Configuration
REQ-028 Macro FP8_MUL_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority (lowest index wins) and the pointer register is removed.
REQ-029 Without FP8_MUL_ARB_FIXED_PRIO_EN, round-robin per REQ-019 and REQ-020 applies.

Verification
REQ-030 Single request: req_valid[0]=1, a=0x30, b=0x40 for 1 cycle, res_ready=1 -> res_valid two cycles later, res_data=0x40, res_id=0.
REQ-031 Round-robin: req_valid=4'b1111 held with a=b=0x38 for all requesters, res_ready=1 -> grants 0,1,2,3,0,1... on consecutive cycles; every res_data=0x42; res_id follows the same sequence.
REQ-032 Backpressure: stream from requester 2 with a=0x30 and b=0x30,0x40,0x38..., res_ready=0 for 5 cycles -> exactly 2 requests accepted, then req_ready=0; after res_ready=1, results 0x30, 0x40, 0x38 arrive in order with none lost.
REQ-033 Reset mid-operation: rst=1 for 1 cycle while S1 and S2 are full -> next cycle res_valid=0; following grant with all requesters valid goes to requester 0; dropped results never appear.
REQ-034 Exceptions: a=0x7F, b=0x30 -> res_data=0x7F; a=0x70, b=0x00 -> res_data=0x7F; a=0x70, b=0x30 -> res_data=0x70.
REQ-035 With FP8_MUL_ARB_FIXED_PRIO_EN defined: req_valid[1] and req_valid[3] held high for 6 cycles -> requester 1 granted every cycle and requester 3 never granted.
